// File: rtl/mk_fifo.sv
// rtl/mk_fifo.sv - token-handshake FIFO with registered head/count outputs
// Occupancy count alone decides full/empty; no empty or full bypass paths.
module mk_fifo #(
  parameter int width = 1,
  parameter int depth = 2
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [((width==0)?1:width)-1:0] IN_ENQ,
  input  logic                         IN_ENQ_VALID,
  output logic                         IN_ENQ_CONSUMED,
  input  logic                         IN_EN_ENQ,
  input  logic                         IN_EN_ENQ_VALID,
  output logic                         IN_EN_ENQ_CONSUMED,
  output logic [((width==0)?1:width)-1:0] OUT_FIRST,
  output logic                         OUT_FIRST_VALID,
  input  logic                         OUT_FIRST_CONSUMED,
  input  logic                         IN_EN_DEQ,
  input  logic                         IN_EN_DEQ_VALID,
  output logic                         IN_EN_DEQ_CONSUMED,
  output logic [$clog2(depth+1)-1:0]   OUT_COUNT
);

  localparam int DW = (width == 0) ? 1 : width;
  localparam int CW = $clog2(depth + 1);
  localparam int PW = $clog2(depth);
  localparam logic DATA_IGNORED = (width == 0);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [PW-1:0] PTR_LAST = PW'(depth - 1);

  logic [DW-1:0] mem_q [depth];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic not_full, not_empty;
  logic enq_in, enq_fire, deq_fire;

  assign not_full  = (count_q < DEPTH_C);
  assign not_empty = (count_q != '0);

  assign enq_in   = (DATA_IGNORED | IN_ENQ_VALID) & IN_EN_ENQ_VALID;
  assign enq_fire = enq_in & IN_EN_ENQ & not_full;
  // Dequeue depends on the downstream consume, but enqueue never does.
  assign deq_fire = IN_EN_DEQ_VALID & IN_EN_DEQ & not_empty &
                    (DATA_IGNORED | OUT_FIRST_CONSUMED);

  assign IN_ENQ_CONSUMED    = enq_in & (~IN_EN_ENQ | not_full);
  assign IN_EN_ENQ_CONSUMED = enq_in & (~IN_EN_ENQ | not_full);
  assign IN_EN_DEQ_CONSUMED = IN_EN_DEQ_VALID & (~IN_EN_DEQ | deq_fire);

  assign OUT_FIRST       = mem_q[head_q];
  assign OUT_FIRST_VALID = not_empty;
  assign OUT_COUNT       = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PW'(1);
    end
    if (deq_fire) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + PW'(1);
    end
    if (enq_fire && !deq_fire) begin
      count_d = count_q + CW'(1);
    end else if (deq_fire && !enq_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge CLK) begin
    if (enq_fire && !RST) begin
      mem_q[tail_q] <= IN_ENQ;
    end
  end

endmodule

// File: tb/tb_mk_fifo.sv
// tb/tb_mk_fifo.sv - scoreboard bench for mk_fifo (width=8, depth=4)
// Driver checks handshakes against a queue model; monitor checks dequeued data.
module tb_mk_fifo;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [W-1:0] IN_ENQ;
  logic         IN_ENQ_VALID, IN_ENQ_CONSUMED;
  logic         IN_EN_ENQ, IN_EN_ENQ_VALID, IN_EN_ENQ_CONSUMED;
  logic [W-1:0] OUT_FIRST;
  logic         OUT_FIRST_VALID, OUT_FIRST_CONSUMED;
  logic         IN_EN_DEQ, IN_EN_DEQ_VALID, IN_EN_DEQ_CONSUMED;
  logic [2:0]   OUT_COUNT;

  mk_fifo #(.width(W), .depth(D)) dut (
    .CLK(CLK), .RST(RST),
    .IN_ENQ(IN_ENQ), .IN_ENQ_VALID(IN_ENQ_VALID), .IN_ENQ_CONSUMED(IN_ENQ_CONSUMED),
    .IN_EN_ENQ(IN_EN_ENQ), .IN_EN_ENQ_VALID(IN_EN_ENQ_VALID),
    .IN_EN_ENQ_CONSUMED(IN_EN_ENQ_CONSUMED),
    .OUT_FIRST(OUT_FIRST), .OUT_FIRST_VALID(OUT_FIRST_VALID),
    .OUT_FIRST_CONSUMED(OUT_FIRST_CONSUMED),
    .IN_EN_DEQ(IN_EN_DEQ), .IN_EN_DEQ_VALID(IN_EN_DEQ_VALID),
    .IN_EN_DEQ_CONSUMED(IN_EN_DEQ_CONSUMED),
    .OUT_COUNT(OUT_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed dequeue handshake must carry the oldest pending entry.
  always @(negedge CLK) begin
    if (!RST && IN_EN_DEQ_VALID && IN_EN_DEQ && IN_EN_DEQ_CONSUMED) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL deq_data: dequeue with empty scoreboard at %0t", $time);
      end else begin
        chk("deq_data", int'(OUT_FIRST), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc(input logic ev, input logic [W-1:0] d, input logic eev,
                     input logic ee, input logic dv, input logic de,
                     input logic fc, input logic rst);
    int  cnt;
    logic enq_in, enq_cons, enq_fire, deq_fire, deq_cons;
    IN_ENQ = d; IN_ENQ_VALID = ev; IN_EN_ENQ_VALID = eev; IN_EN_ENQ = ee;
    IN_EN_DEQ_VALID = dv; IN_EN_DEQ = de; OUT_FIRST_CONSUMED = fc; RST = rst;
    #3;
    cnt      = model_q.size();
    enq_in   = ev && eev;
    enq_cons = enq_in && (!ee || cnt < D);
    enq_fire = enq_in && ee && cnt < D;
    deq_fire = dv && de && cnt > 0 && fc;
    deq_cons = dv && (!de || deq_fire);
    chk("out_count", int'(OUT_COUNT), cnt);
    chk("first_valid", int'(OUT_FIRST_VALID), int'(cnt > 0));
    if (cnt > 0) chk("out_first", int'(OUT_FIRST), int'(model_q[0]));
    chk("enq_consumed", int'(IN_ENQ_CONSUMED), int'(enq_cons));
    chk("en_enq_consumed", int'(IN_EN_ENQ_CONSUMED), int'(enq_cons));
    chk("en_deq_consumed", int'(IN_EN_DEQ_CONSUMED), int'(deq_cons));
    @(posedge CLK);
    if (rst) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (deq_fire) void'(model_q.pop_front());
      if (enq_fire) begin
        model_q.push_back(d);
        exp_q.push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic enq(input logic [W-1:0] d);
    cyc(1, d, 1, 1, 0, 0, 0, 0);
  endtask
  task automatic deq();
    cyc(0, '0, 0, 0, 1, 1, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(0, '0, 0, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    cyc(0, '0, 0, 0, 0, 0, 0, 1);
    idle();

    // Two enqueues, then head shows the first.
    enq(8'h11); enq(8'h22); idle();
    deq(); deq(); idle();

    // Fill, hold A4 while full, release on a dequeue.
    for (int i = 0; i < 4; i++) enq(8'hA0 + 8'(i));
    cyc(1, 8'hA4, 1, 1, 0, 0, 0, 0);
    cyc(1, 8'hA4, 1, 1, 0, 0, 0, 0);
    cyc(1, 8'hA4, 1, 1, 1, 1, 1, 0);
    cyc(1, 8'hA4, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) deq();
    idle();

    // Dequeue on empty waits until data is present.
    deq();
    cyc(1, 8'h5A, 1, 1, 1, 1, 1, 0);
    deq();
    idle();

    // Steady-state simultaneous enq/deq across pointer wrap.
    enq(8'h30); enq(8'h31);
    for (int i = 0; i < 8; i++) cyc(1, 8'h33 + 8'(i), 1, 1, 1, 1, 1, 0);
    deq(); deq(); idle();

    // Enable-0 tokens are consumed without effect.
    enq(8'h77);
    cyc(1, 8'hEE, 1, 0, 1, 0, 1, 0);
    cyc(1, 8'hEE, 1, 0, 1, 0, 1, 0);
    deq(); idle();

    // Reset during simultaneous enq/deq discards everything.
    enq(8'h01); enq(8'h02); enq(8'h03);
    cyc(1, 8'h04, 1, 1, 1, 1, 1, 1);
    idle();
    deq();
    idle();

    // Random traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 60) == 0));
    end
    for (int i = 0; i < 6; i++) deq();
    idle();
    chk("scoreboard_drained", exp_q.size(), model_q.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mk_fifo.md
MK_FIFO -- requirements
Module: mk_fifo

Interface
REQ-001 Parameter width, default 1, data bits per entry; width 0 SHALL be treated as a 1-bit datapath whose data is ignored.
REQ-002 Parameter depth, default 2, number of entries; legal range 2..256.
REQ-003 CLK  in  1  sole clock; all state SHALL update on posedge CLK.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 IN_ENQ  in  width  enqueue data token.
REQ-006 IN_ENQ_VALID  in  1  IN_ENQ token present.
REQ-007 IN_ENQ_CONSUMED  out  1  IN_ENQ token taken this cycle.
REQ-008 IN_EN_ENQ  in  1  enqueue enable token value.
REQ-009 IN_EN_ENQ_VALID  in  1  IN_EN_ENQ token present.
REQ-010 IN_EN_ENQ_CONSUMED  out  1  IN_EN_ENQ token taken this cycle.
REQ-011 OUT_FIRST  out  width  head-entry data.
REQ-012 OUT_FIRST_VALID  out  1  head entry present.
REQ-013 OUT_FIRST_CONSUMED  in  1  downstream has taken OUT_FIRST.
REQ-014 IN_EN_DEQ  in  1  dequeue enable token value.
REQ-015 IN_EN_DEQ_VALID  in  1  IN_EN_DEQ token present.
REQ-016 IN_EN_DEQ_CONSUMED  out  1  IN_EN_DEQ token taken this cycle.
REQ-017 OUT_COUNT  out  clog2(depth+1)  current occupancy.

Function
REQ-018 State: storage array depth x width, head pointer, tail pointer, occupancy count; count SHALL be the sole full/empty source.
REQ-019 enqIn = (width==0 ? 1 : IN_ENQ_VALID) && IN_EN_ENQ_VALID.
REQ-020 enqFire = enqIn && IN_EN_ENQ && count < depth, with count sampled at the start of the cycle.
REQ-021 IN_ENQ_CONSUMED = IN_EN_ENQ_CONSUMED = enqIn && (!IN_EN_ENQ || count < depth); a token pair with enable 0 SHALL be consumed without writing storage.
REQ-022 Full (count==depth) with IN_EN_ENQ=1: both enqueue CONSUMED = 0; tokens held by producer until space.
REQ-023 enqFire: storage[tail] <= IN_ENQ; tail advances, wrapping depth-1 -> 0.
REQ-024 OUT_FIRST = storage[head]; OUT_FIRST_VALID = (count != 0); no empty bypass (enqueued data visible no earlier than next cycle).
REQ-025 deqFire = IN_EN_DEQ_VALID && IN_EN_DEQ && count != 0 && (width==0 ? 1 : OUT_FIRST_CONSUMED).
REQ-026 IN_EN_DEQ_CONSUMED = IN_EN_DEQ_VALID && (!IN_EN_DEQ || deqFire); dequeue token with enable 0 SHALL be consumed immediately.
REQ-027 Empty with IN_EN_DEQ=1: IN_EN_DEQ_CONSUMED = 0, no state change.
REQ-028 deqFire: head advances, wrapping depth-1 -> 0.
REQ-029 Simultaneous enqFire and deqFire: both complete; count unchanged; pointers both advance.
REQ-030 Full with simultaneous enqueue and dequeue: dequeue fires; enqueue SHALL NOT fire that cycle (no full-bypass; no combinational path CONSUMED-in to ENQ_CONSUMED-out).
REQ-031 count +1 on enqFire only, -1 on deqFire only; SHALL never exceed depth nor underflow.
REQ-032 OUT_COUNT = count; all outputs purely from registers except the CONSUMED outputs.

Reset
REQ-033 RST=1 at posedge: count, head, tail <= 0; OUT_FIRST_VALID = 0, OUT_COUNT = 0 the following cycle; storage not cleared.
REQ-034 RST mid-operation SHALL discard all entries; any enqFire/deqFire in the reset cycle SHALL be ignored.
REQ-035 While RST=1, all CONSUMED outputs still follow REQ-021/026 combinationally; state effects suppressed.

Verification (width=8, depth=4)
REQ-036 Reset, then enqueue 0x11,0x22 on consecutive cycles, EN_ENQ=1 -> OUT_COUNT=2, OUT_FIRST=0x11, OUT_FIRST_VALID=1.
REQ-037 Fill with 0xA0..0xA3, present 0xA4 -> IN_ENQ_CONSUMED=0 held until a dequeue, then 0xA4 accepted the next cycle; drain order A1,A2,A3,A4.
REQ-038 Empty, IN_EN_DEQ=1 valid -> IN_EN_DEQ_CONSUMED=0, OUT_FIRST_VALID=0; enqueue 0x5A -> dequeue consumed the cycle after.
REQ-039 count=2, simultaneous enqueue 0x33 and dequeue -> count stays 2, head/tail both advance; 8 such cycles verify pointer wrap and FIFO order.
REQ-040 EN_ENQ=0 and EN_DEQ=0 tokens valid -> both CONSUMED=1 same cycle, count unchanged.
REQ-041 count=3, assert RST one cycle during simultaneous enq/deq -> next cycle OUT_COUNT=0, OUT_FIRST_VALID=0.
